// File: rtl/regfile_debug_access_ctrl.sv
// Debug host access to the core register file.
// The controller halts the core at an instruction boundary and borrows the write
// port and read port 1 for exactly one access. It then reloads the core's read
// outputs and releases the core.
module regfile_debug_access_ctrl #(
  parameter int unsigned NUM_REGS     = 36,
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n_i,
  // core side
  input  logic        core_ce_i,
  input  logic        core_wr_en_i,
  input  logic [5:0]  core_wr_sel_i,
  input  logic [31:0] core_wr_data_i,
  input  logic [5:0]  core_rd1_sel_i,
  input  logic [5:0]  core_rd2_sel_i,
  input  logic        core_idle_i,
  output logic        core_stall_o,
  // debug host side
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [5:0]  dbg_sel_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ready_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,
  // register file side
  output logic        rf_ce_o,
  output logic [31:0] rf_in_o,
  output logic [5:0]  rf_in_sel_o,
  output logic        rf_in_en_o,
  output logic [5:0]  rf_out1_sel_o,
  output logic [5:0]  rf_out2_sel_o,
  input  logic [31:0] rf_out1_i
);

  localparam int unsigned CW = $clog2(HALT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ACCESS,
    S_RESTORE,
    S_RESP
  } state_t;

  state_t        r_state;
  logic          r_we;
  logic [5:0]    r_sel;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_sel_ok;
  logic          w_timeout;

  assign w_sel_ok  = (32'(dbg_sel_i) < NUM_REGS);
  assign w_timeout = (32'(r_cnt) == (HALT_TIMEOUT - 1));

  // Access sequencer: accept, halt, one-cycle access, restore, respond
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dbg_req_i) begin
            r_we    <= dbg_we_i;
            r_sel   <= dbg_sel_i;
            r_wdata <= dbg_wdata_i;
            r_rdata <= '0;
            r_cnt   <= '0;
            if (w_sel_ok) begin
              r_err   <= 1'b0;
              r_state <= S_HALT;
            end else begin
              // Out-of-range index: answer at once without touching the core
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end
          end
        end
        S_HALT: begin
          // Idle takes priority over timeout when both occur in the same cycle
          if (core_idle_i) begin
            r_state <= S_ACCESS;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACCESS: begin
          r_state <= S_RESTORE;
        end
        S_RESTORE: begin
          r_rdata <= r_we ? '0 : rf_out1_i;
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign core_stall_o = (r_state == S_HALT) || (r_state == S_ACCESS) ||
                        (r_state == S_RESTORE);
  assign dbg_ready_o  = (r_state == S_IDLE);
  assign dbg_rvalid_o = (r_state == S_RESP);
  assign dbg_rdata_o  = r_rdata;
  assign dbg_err_o    = r_err;

  // Register-file port ownership: core by default, controller in ACCESS/RESTORE
  always_comb begin
    rf_ce_o       = core_ce_i;
    rf_in_o       = core_wr_data_i;
    rf_in_sel_o   = core_wr_sel_i;
    rf_in_en_o    = core_wr_en_i;
    rf_out1_sel_o = core_rd1_sel_i;
    rf_out2_sel_o = core_rd2_sel_i;
    case (r_state)
      S_ACCESS: begin
        rf_ce_o       = 1'b1;
        rf_in_o       = r_wdata;
        rf_in_sel_o   = r_sel;
        rf_in_en_o    = r_we;
        rf_out1_sel_o = r_sel;
      end
      S_RESTORE: begin
        // Clocked edge with the core's select reloads the core's read data
        rf_ce_o       = 1'b1;
        rf_in_o       = r_wdata;
        rf_in_sel_o   = r_sel;
        rf_in_en_o    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_debug_access_ctrl.sv
// Bench for regfile_debug_access_ctrl. It includes a behavioural register-file
// model and a response scoreboard.
module tb_regfile_debug_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        core_ce_i = 1'b0;
  logic        core_wr_en_i = 1'b0;
  logic [5:0]  core_wr_sel_i = '0;
  logic [31:0] core_wr_data_i = '0;
  logic [5:0]  core_rd1_sel_i = '0;
  logic [5:0]  core_rd2_sel_i = '0;
  logic        core_idle_i = 1'b1;
  logic        core_stall_o;
  logic        dbg_req_i = 1'b0;
  logic        dbg_we_i = 1'b0;
  logic [5:0]  dbg_sel_i = '0;
  logic [31:0] dbg_wdata_i = '0;
  logic        dbg_ready_o;
  logic        dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;
  logic        dbg_err_o;
  logic        rf_ce_o;
  logic [31:0] rf_in_o;
  logic [5:0]  rf_in_sel_o;
  logic        rf_in_en_o;
  logic [5:0]  rf_out1_sel_o;
  logic [5:0]  rf_out2_sel_o;
  logic [31:0] rf_out1_i = '0;

  regfile_debug_access_ctrl #(.NUM_REGS(36), .HALT_TIMEOUT(8)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .core_ce_i(core_ce_i), .core_wr_en_i(core_wr_en_i), .core_wr_sel_i(core_wr_sel_i),
    .core_wr_data_i(core_wr_data_i), .core_rd1_sel_i(core_rd1_sel_i),
    .core_rd2_sel_i(core_rd2_sel_i), .core_idle_i(core_idle_i), .core_stall_o(core_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_sel_i(dbg_sel_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ready_o(dbg_ready_o), .dbg_rvalid_o(dbg_rvalid_o),
    .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
    .rf_ce_o(rf_ce_o), .rf_in_o(rf_in_o), .rf_in_sel_o(rf_in_sel_o), .rf_in_en_o(rf_in_en_o),
    .rf_out1_sel_o(rf_out1_sel_o), .rf_out2_sel_o(rf_out2_sel_o), .rf_out1_i(rf_out1_i)
  );

  always #5 clk = ~clk;

  // Register file: x0 hardwired to zero, registered read port 1
  logic [31:0] rf_mem [36] = '{default: '0};
  always @(posedge clk) begin
    if (rf_ce_o) begin
      if (rf_in_en_o && rf_in_sel_o != 6'd0 && rf_in_sel_o < 6'd36)
        rf_mem[rf_in_sel_o] <= rf_in_o;
      rf_out1_i <= (rf_out1_sel_o < 6'd36) ? rf_mem[rf_out1_sel_o] : 32'h0;
    end
  end

  int unsigned cyc = 0;
  int unsigned ce_cnt = 0;
  int unsigned stall_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rf_ce_o) ce_cnt <= ce_cnt + 1;
    if (core_stall_o) stall_cnt <= stall_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response strobe is matched against the oldest expectation
  always @(negedge clk) begin
    if (dbg_rvalid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_err", {31'b0, dbg_err_o}, {31'b0, e.err});
        if (e.chk_rdata) chk("resp_rdata", dbg_rdata_o, e.rdata);
        chk("resp_stall", {31'b0, core_stall_o}, 32'd0);
      end
    end
  end

  // Drive a request for one cycle (caller is at a negedge in an IDLE cycle)
  task automatic send(input logic we, input logic [5:0] sel, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic chk_rd, input logic exp_err,
                      input int unsigned lat);
    exp_t e;
    chk("ready_before_req", {31'b0, dbg_ready_o}, 32'd1);
    dbg_req_i = 1'b1; dbg_we_i = we; dbg_sel_i = sel; dbg_wdata_i = wd;
    e.rdata = exp_rd; e.chk_rdata = chk_rd; e.err = exp_err; e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    dbg_req_i = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (n < 40 && !(sb.size() == 0 && dbg_ready_o)) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= 40) chk("resp_timeout", 32'd1, 32'd0);
  endtask

  int unsigned snap;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, dbg_ready_o}, 32'd1);
    chk("rst_stall", {31'b0, core_stall_o}, 32'd0);
    chk("rst_rvalid", {31'b0, dbg_rvalid_o}, 32'd0);
    chk("rst_rdata", dbg_rdata_o, 32'd0);
    chk("rst_err", {31'b0, dbg_err_o}, 32'd0);
    reset_n_i = 1'b1;
    @(negedge clk);

    // write x5, check ACCESS cycle drive
    @(negedge clk);
    send(1'b1, 6'd5, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 4);
    @(negedge clk);
    chk("acc_ce", {31'b0, rf_ce_o}, 32'd1);
    chk("acc_wen", {31'b0, rf_in_en_o}, 32'd1);
    chk("acc_wsel", {26'b0, rf_in_sel_o}, 32'd5);
    chk("acc_wdata", rf_in_o, 32'hDEADBEEF);
    wait_done();

    @(negedge clk);
    send(1'b0, 6'd5, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 4);
    wait_done();

    // read q2 while the core selects x7 on read port 1
    @(negedge clk);
    send(1'b1, 6'd7, 32'h77770007, 32'h0, 1'b1, 1'b0, 4);
    wait_done();
    @(negedge clk);
    send(1'b1, 6'd34, 32'h12345678, 32'h0, 1'b1, 1'b0, 4);
    wait_done();
    core_rd1_sel_i = 6'd7;
    @(negedge clk);
    send(1'b0, 6'd34, 32'h0, 32'h12345678, 1'b1, 1'b0, 4);
    @(negedge clk);
    chk("acc_rsel", {26'b0, rf_out1_sel_o}, 32'd34);
    @(negedge clk);
    chk("rst_rsel", {26'b0, rf_out1_sel_o}, 32'd7);
    chk("rst_wen", {31'b0, rf_in_en_o}, 32'd0);
    @(negedge clk);
    chk("core_rd1_reloaded", rf_out1_i, 32'h77770007);
    wait_done();

    // halt timeout: no access, error response
    @(negedge clk);
    core_idle_i = 1'b0;
    snap = ce_cnt;
    send(1'b1, 6'd9, 32'h99999999, 32'h0, 1'b0, 1'b1, 9);
    wait_done();
    chk("timeout_no_ce", ce_cnt - snap, 32'd0);
    core_idle_i = 1'b1;
    @(negedge clk);
    send(1'b0, 6'd9, 32'h0, 32'h0, 1'b1, 1'b0, 4);
    wait_done();

    // out-of-range select
    @(negedge clk);
    snap = stall_cnt;
    send(1'b0, 6'd40, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    wait_done();
    chk("badsel_no_stall", stall_cnt - snap, 32'd0);

    // core write-back in the accept cycle, idle two cycles later
    @(negedge clk);
    core_idle_i = 1'b0;
    core_ce_i = 1'b1; core_wr_en_i = 1'b1; core_wr_sel_i = 6'd3; core_wr_data_i = 32'hCAFE0003;
    send(1'b0, 6'd3, 32'h0, 32'hCAFE0003, 1'b1, 1'b0, 5);
    core_ce_i = 1'b0; core_wr_en_i = 1'b0;
    @(negedge clk);
    core_idle_i = 1'b1;
    wait_done();

    // reset during ACCESS drops the request
    @(negedge clk);
    send(1'b0, 6'd5, 32'h0, 32'h0, 1'b0, 1'b0, 4);
    @(negedge clk);
    reset_n_i = 1'b0;
    #1;
    chk("midrst_stall", {31'b0, core_stall_o}, 32'd0);
    chk("midrst_ready", {31'b0, dbg_ready_o}, 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    repeat (3) @(negedge clk);
    send(1'b0, 6'd5, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 4);
    wait_done();

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule

// File: doc/regfile_debug_access_ctrl.md
Name: regfile_debug_access_ctrl

Overview:
- Gives a debug host (UART/JTAG debugger) read/write access to the 36-entry register file (x0–x31, q0–q3) while the core runs.
- Halts the core at an instruction boundary, then takes over the single write port and read port 1 for one access.
- Restores the register-file read outputs to the core's selects, then releases the core.
- Sits between the core pipeline and the register file and drives all register-file control inputs.

Parameters:
- NUM_REGS, 36, number of valid register indices; any sel >= NUM_REGS is an error.
- HALT_TIMEOUT, 255, max cycles spent waiting for core_idle_i before the access is abandoned with an error.

Ports:
- clk  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- core_ce_i  in  1  core clock-enable to the register file
- core_wr_en_i  in  1  core write-back enable
- core_wr_sel_i  in  6  core write-back register index
- core_wr_data_i  in  32  core write-back data
- core_rd1_sel_i  in  6  core read port 1 select
- core_rd2_sel_i  in  6  core read port 2 select
- core_idle_i  in  1  core drained; no write-back in flight
- core_stall_o  out  1  core must not issue new instructions
- dbg_req_i  in  1  debug request valid
- dbg_we_i  in  1  1 = write, 0 = read
- dbg_sel_i  in  6  target register index
- dbg_wdata_i  in  32  write data
- dbg_ready_o  out  1  request accepted when dbg_req_i && dbg_ready_o
- dbg_rvalid_o  out  1  one-cycle response strobe
- dbg_rdata_o  out  32  read data, valid with dbg_rvalid_o
- dbg_err_o  out  1  error flag, valid with dbg_rvalid_o
- rf_ce_o  out  1  register-file clock enable
- rf_in_o  out  32  register-file write data
- rf_in_sel_o  out  6  register-file write index
- rf_in_en_o  out  1  register-file write enable
- rf_out1_sel_o  out  6  register-file read select 1
- rf_out2_sel_o  out  6  register-file read select 2
- rf_out1_i  in  32  register-file read data 1 (registered; valid the cycle after a ce'd edge)

Behaviour:
- Reset (async, active-low): state IDLE, halt counter 0, dbg_rdata_o 0, dbg_err_o 0, dbg_rvalid_o 0, core_stall_o 0, dbg_ready_o 1. Reset mid-transaction drops the request with no response.
- State machine: IDLE, HALT, ACCESS, RESTORE, RESP.
- Outputs decoded from state:
  - core_stall_o = 1 in HALT, ACCESS, RESTORE.
  - dbg_ready_o = 1 only in IDLE.
  - dbg_rvalid_o = 1 only in RESP.
- Register-file mux (combinational, zero latency):
  - IDLE, HALT, RESP: rf_* = core_* pass-through.
  - ACCESS: rf_ce_o=1, rf_in_en_o=latched we, rf_in_sel_o=rf_out1_sel_o=latched sel, rf_in_o=latched wdata, rf_out2_sel_o=core_rd2_sel_i.
  - RESTORE: rf_ce_o=1, rf_in_en_o=0, rf_out1_sel_o=core_rd1_sel_i, rf_out2_sel_o=core_rd2_sel_i.
- IDLE:
  - On handshake, latch we/sel/wdata and clear dbg_err_o.
  - sel < NUM_REGS: go to HALT, counter reset to 0.
  - sel >= NUM_REGS: go directly to RESP with err=1; no stall, no register-file access.
  - dbg_req_i while not ready is ignored; the requester holds the request.
- HALT:
  - The core keeps the register file so in-flight write-backs complete.
  - core_idle_i=1: go to ACCESS.
  - Otherwise the counter increments; at count == HALT_TIMEOUT-1 go to RESP with err=1 and no access.
  - core_idle_i and timeout in the same cycle: idle wins.
- ACCESS (1 cycle): write performed, or read data registered into rf_out1_i. Writes to x0 are silently ignored by the register file; no error. Go to RESTORE.
- RESTORE (1 cycle):
  - If read, capture rf_out1_i into dbg_rdata_o; if write, dbg_rdata_o=0.
  - The ce'd edge reloads the core's read outputs.
  - Go to RESP.
- RESP (1 cycle): rvalid=1, stall released. Next state IDLE. dbg_rdata_o/dbg_err_o hold until the next accepted request.
- Minimum latency, handshake to rvalid:
  - Core already idle: 4 cycles (HALT, ACCESS, RESTORE, RESP).
  - Timeout: HALT_TIMEOUT+1 cycles.
  - Bad sel: 1 cycle.

Test Plan:
- Core idle, debug write x5=0xDEADBEEF -> rf_in_en_o=1, sel=5 in ACCESS; rvalid 4 cycles after accept; err=0; a later debug read of x5 returns 0xDEADBEEF.
- Debug read of q2 (sel=34) holding 0x12345678, core_rd1_sel_i=7 -> rdata=0x12345678; in RESTORE rf_out1_sel_o=7, so after release rf_out1_i shows x7.
- core_idle_i held low, HALT_TIMEOUT=8 -> rvalid 9 cycles after accept, err=1, no rf_ce_o from the controller; core_stall_o drops in RESP.
- dbg_sel_i=40 -> rvalid the next cycle, err=1, core_stall_o never asserted.
- Core write-back to x3 in the accept cycle, core_idle_i rises 2 cycles later -> core write lands; debug read of x3 returns the core's value.
- Assert reset_n_i low during ACCESS -> immediate IDLE, stall=0, rvalid never pulses; the next request completes normally.
